// File: rtl/phys_pkg.sv
// Shared physics types for the collision path.
// Holds the object record layout used by the object table, the
// collision detector and the scheduler, the fixed-point constants
// that describe that layout, and the scheduler state encoding.
package phys_pkg;

    // One object table record. Positions and velocities are Q8.24,
    // orientation axes u/v are Q2.14 unit vectors, width/height are
    // integer half-extents along u and v respectively.
    typedef struct packed {
        logic signed [7:0]  width;
        logic signed [7:0]  height;
        logic signed [31:0] pos_x;
        logic signed [31:0] pos_y;
        logic signed [31:0] vel_x;
        logic signed [31:0] vel_y;
        logic signed [15:0] u_x;
        logic signed [15:0] u_y;
        logic signed [15:0] v_x;
        logic signed [15:0] v_y;
    } object_t;

    localparam int                 OBJ_W        = $bits(object_t);
    localparam logic signed [15:0] FIX_ONE_Q214 = 16'sh4000;
    localparam int                 FRAC_POS     = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_LAT_A,
        S_RD_B,
        S_LAT_B,
        S_CHECK,
        S_EMIT,
        S_DONE
    } sched_state_e;

endpackage

// File: rtl/collision_detector.sv
// Combinational oriented-box overlap test (separating axis theorem).
// Ports:
//   a_i, b_i        object records of the two boxes under test
//   is_collision_o  1 when no separating axis exists (touching counts as hit)
// The four candidate axes are the u/v axes of both boxes. Projections of
// the centre offset are in Q38 (Q24 * Q14); radii are built in Q28
// (integer extent * Q14 * Q14) and shifted up to Q38 before comparison.
module collision_detector
    import phys_pkg::*;
(
    input  object_t a_i,
    input  object_t b_i,
    output logic    is_collision_o
);

    function automatic logic signed [63:0] absVal(input logic signed [63:0] x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic signed [63:0] dotQ28(input logic signed [15:0] px,
                                                  input logic signed [15:0] py,
                                                  input logic signed [15:0] qx,
                                                  input logic signed [15:0] qy);
        return 64'(px) * 64'(qx) + 64'(py) * 64'(qy);
    endfunction

    function automatic logic separatedOn(input object_t a, input object_t b,
                                         input logic signed [15:0] axX,
                                         input logic signed [15:0] axY);
        logic signed [63:0] dx;
        logic signed [63:0] dy;
        logic signed [63:0] proj;
        logic signed [63:0] radA;
        logic signed [63:0] radB;
        dx   = 64'(b.pos_x) - 64'(a.pos_x);
        dy   = 64'(b.pos_y) - 64'(a.pos_y);
        proj = absVal(dx * 64'(axX) + dy * 64'(axY));
        radA = 64'(a.width)  * absVal(dotQ28(a.u_x, a.u_y, axX, axY))
             + 64'(a.height) * absVal(dotQ28(a.v_x, a.v_y, axX, axY));
        radB = 64'(b.width)  * absVal(dotQ28(b.u_x, b.u_y, axX, axY))
             + 64'(b.height) * absVal(dotQ28(b.v_x, b.v_y, axX, axY));
        return proj > ((radA + radB) <<< (FRAC_POS - 14));
    endfunction

    // Velocities play no part in a static overlap test.
    logic unusedVel;
    assign unusedVel = ^{a_i.vel_x, a_i.vel_y, b_i.vel_x, b_i.vel_y};

    assign is_collision_o = !(separatedOn(a_i, b_i, a_i.u_x, a_i.u_y) ||
                              separatedOn(a_i, b_i, a_i.v_x, a_i.v_y) ||
                              separatedOn(a_i, b_i, b_i.u_x, b_i.u_y) ||
                              separatedOn(a_i, b_i, b_i.v_x, b_i.v_y));

endmodule

// File: rtl/pair_iter.sv
// Pair index generator for the collision scan.
// Walks (i,j) over all i<j<n in lexicographic order.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   init_i       load i=0, j=1 and capture n_i as the scan length
//   advance_i    step to the next pair
//   n_i          clamped object count, captured only on init_i
//   i_o, j_o     current pair indices
//   newRow_o     the next pair starts a new i (A record must be re-read)
//   lastPair_o   current pair is the final one of the scan
module pair_iter #(
    parameter int NUM_OBJ = 8,
    parameter int IDX_W   = $clog2(NUM_OBJ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_i,
    input  logic             advance_i,
    input  logic [IDX_W:0]   n_i,
    output logic [IDX_W-1:0] i_o,
    output logic [IDX_W-1:0] j_o,
    output logic             newRow_o,
    output logic             lastPair_o
);

    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [IDX_W:0]   n_q, n_d;
    logic [IDX_W:0]   jNext;
    logic [IDX_W:0]   iPlus2;

    // Comparisons are done one bit wider so j+1 / i+2 never wrap.
    assign jNext      = {1'b0, j_q} + (IDX_W+1)'(1);
    assign iPlus2     = {1'b0, i_q} + (IDX_W+1)'(2);
    assign newRow_o   = !(jNext < n_q);
    assign lastPair_o = newRow_o && !(iPlus2 < n_q);
    assign i_o        = i_q;
    assign j_o        = j_q;

    // Next pair: move along the row, else start the next row at j=i+2
    // (i+1 paired with its first partner), else hold on the last pair.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        n_d = n_q;
        if (init_i) begin
            i_d = '0;
            j_d = IDX_W'(1);
            n_d = n_i;
        end else if (advance_i) begin
            if (!newRow_o) begin
                j_d = j_q + 1'b1;
            end else if (!lastPair_o) begin
                i_d = i_q + 1'b1;
                j_d = iPlus2[IDX_W-1:0];
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
            n_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            n_q <= n_d;
        end
    end

endmodule

// File: rtl/collision_scheduler.sv
// Frame-level collision scan sequencer.
// Reads object pairs from the object table, runs them through the
// combinational collision detector and streams every hit out as an
// (a,b) index pair.
// Ports:
//   Clk, Reset_n       clock, async active-low reset
//   start, num_active  scan request (IDLE only) and live object count
//   busy, done         scan in progress / one-cycle end-of-scan pulse
//   obj_rd_en/idx/data object table read port, data one cycle after en
//   hit_valid/ready    hit stream handshake, hit_a < hit_b
//   hit_count          saturating number of hits in the current/last scan
module collision_scheduler
    import phys_pkg::*;
#(
    parameter int NUM_OBJ = 8,
    parameter int IDX_W   = $clog2(NUM_OBJ),
    parameter int CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [IDX_W:0]   num_active,
    output logic             busy,
    output logic             done,
    output logic             obj_rd_en,
    output logic [IDX_W-1:0] obj_rd_idx,
    input  object_t          obj_rd_data,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [IDX_W-1:0] hit_a,
    output logic [IDX_W-1:0] hit_b,
    output logic [CNT_W-1:0] hit_count
);

    sched_state_e     state_q, state_d;
    sched_state_e     advanceState;
    object_t          regA_q, regA_d;
    object_t          regB_q, regB_d;
    logic [CNT_W-1:0] hitCount_q, hitCount_d;
    logic [IDX_W:0]   nClamped;
    logic             iterInit;
    logic             iterAdvance;
    logic [IDX_W-1:0] iIdx;
    logic [IDX_W-1:0] jIdx;
    logic             newRow;
    logic             lastPair;
    logic             isCollision;

    assign nClamped = (num_active > (IDX_W+1)'(NUM_OBJ)) ? (IDX_W+1)'(NUM_OBJ) : num_active;

    pair_iter #(
        .NUM_OBJ (NUM_OBJ),
        .IDX_W   (IDX_W)
    ) u_pair_iter (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .init_i     (iterInit),
        .advance_i  (iterAdvance),
        .n_i        (nClamped),
        .i_o        (iIdx),
        .j_o        (jIdx),
        .newRow_o   (newRow),
        .lastPair_o (lastPair)
    );

    // Detector only ever sees the registered operands.
    collision_detector u_detector (
        .a_i            (regA_q),
        .b_i            (regB_q),
        .is_collision_o (isCollision)
    );

    // Where to go after the current pair is finished; within a row the
    // A record stays in regA so only B is re-read.
    assign advanceState = lastPair ? S_DONE : (newRow ? S_RD_A : S_RD_B);

    // Next-state, datapath loads and read-port control.
    always_comb begin
        state_d     = state_q;
        regA_d      = regA_q;
        regB_d      = regB_q;
        hitCount_d  = hitCount_q;
        iterInit    = 1'b0;
        iterAdvance = 1'b0;
        obj_rd_en   = 1'b0;
        obj_rd_idx  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hitCount_d = '0;
                    if (nClamped >= (IDX_W+1)'(2)) begin
                        iterInit = 1'b1;
                        state_d  = S_RD_A;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end
            S_RD_A: begin
                obj_rd_en  = 1'b1;
                obj_rd_idx = iIdx;
                state_d    = S_LAT_A;
            end
            S_LAT_A: begin
                regA_d  = obj_rd_data;
                state_d = S_RD_B;
            end
            S_RD_B: begin
                obj_rd_en  = 1'b1;
                obj_rd_idx = jIdx;
                state_d    = S_LAT_B;
            end
            S_LAT_B: begin
                regB_d  = obj_rd_data;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (isCollision) begin
                    if (hitCount_q != '1) begin
                        hitCount_d = hitCount_q + 1'b1;
                    end
                    state_d = S_EMIT;
                end else begin
                    iterAdvance = 1'b1;
                    state_d     = advanceState;
                end
            end
            S_EMIT: begin
                if (hit_ready) begin
                    iterAdvance = 1'b1;
                    state_d     = advanceState;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            regA_q     <= '0;
            regB_q     <= '0;
            hitCount_q <= '0;
        end else begin
            state_q    <= state_d;
            regA_q     <= regA_d;
            regB_q     <= regB_d;
            hitCount_q <= hitCount_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign hit_valid = (state_q == S_EMIT);
    assign hit_a     = iIdx;
    assign hit_b     = jIdx;
    assign hit_count = hitCount_q;

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Sequences the combinational `collision_detector` across all unordered object pairs (i<j) held in the object table.
- On `start`, reads object records from the table through a 1-cycle-latency read port and registers operands A and B.
- Samples `is_collision` for each pair and emits each hit as an (a,b) index pair on a valid/ready stream.
- Sits between the object table / physics update and the collision-response logic. Runs once per frame.

Parameters:
- NUM_OBJ, 8, number of table slots (2..64).
- IDX_W, $clog2(NUM_OBJ), index width.
- CNT_W, 8, width of the hit counter.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to scan; honoured only in IDLE.
- num_active  in  IDX_W+1  number of live objects, slots 0..num_active-1; values above NUM_OBJ are clamped to NUM_OBJ.
- busy  out  1  high from the cycle after an accepted start through DONE.
- done  out  1  one-cycle pulse at end of scan.
- obj_rd_en  out  1  table read strobe.
- obj_rd_idx  out  IDX_W  table read index.
- obj_rd_data  in  object_t  record; valid the cycle after obj_rd_en.
- hit_valid  out  1  hit pair available.
- hit_ready  in  1  consumer accepts.
- hit_a  out  IDX_W  lower index of the hit pair.
- hit_b  out  IDX_W  higher index of the hit pair.
- hit_count  out  CNT_W  hits in the current/last scan; saturates at all-ones.

Behaviour:
- Reset (async, Reset_n=0):
  - State IDLE.
  - busy, done, obj_rd_en, hit_valid, hit_a, hit_b, obj_rd_idx all 0.
  - hit_count 0; i, j 0; regA, regB 0.
  - Reset mid-scan abandons the scan; no done pulse.
- FSM states: IDLE, RD_A, LAT_A, RD_B, LAT_B, CHECK, EMIT, DONE.
- IDLE:
  - start=1 and clamped n>=2: i<=0, j<=1, hit_count<=0, go to RD_A.
  - start=1 and n<2: hit_count<=0, go to DONE; no reads are issued.
  - start=0: stay in IDLE.
- RD_A: obj_rd_en=1, obj_rd_idx=i, go to LAT_A.
- LAT_A: regA<=obj_rd_data, go to RD_B.
- RD_B: obj_rd_en=1, obj_rd_idx=j, go to LAT_B.
- LAT_B: regB<=obj_rd_data, go to CHECK.
- CHECK:
  - Detector inputs are driven only from regA/regB, never directly from obj_rd_data.
  - is_collision=1: hit_count increments (saturating), go to EMIT.
  - is_collision=0: advance.
- EMIT:
  - hit_valid=1, hit_a=i, hit_b=j.
  - hit_a/hit_b stay stable until hit_valid&&hit_ready.
  - On that transfer: advance, with hit_valid low the next cycle.
  - hit_ready asserted on entry gives a 1-cycle EMIT.
  - The FSM stalls indefinitely while hit_ready=0.
- Advance:
  - If j<n-1: j<=j+1, go to RD_B (A is reused).
  - Else if i<n-2: i<=i+1, j<=i+2, go to RD_A.
  - Else go to DONE.
- DONE: done=1 for one cycle, go to IDLE. busy=0 in IDLE.
- start while busy is ignored and not queued.
- Latency, no hits: 2(n-1) + 3·n(n-1)/2 + 1 cycles from start acceptance to the done pulse.
  - n=2 gives 6.
  - n=3 gives 14.
  - Each hit adds 1 + stall cycles.
- Pair order is lexicographic (0,1),(0,2)…(n-2,n-1). Each unordered pair is tested exactly once, and no self-pairs are tested.
- num_active is sampled only at start acceptance; later changes have no effect on the running scan.

Decomposition:
- Shared package `phys_pkg`:
  - `object_t` packed struct: width s8, height s8 (half-extents).
  - pos_x, pos_y, vel_x, vel_y: s32, Q8.24.
  - u_x, u_y, v_x, v_y: s16, Q2.14 (1.0=16'h4000).
  - Constants OBJ_W, FIX_ONE_Q214, FRAC_POS=24.
  - FSM state enum.
- Instantiates the existing `collision_detector` once. The A/B ports are driven from regA/regB fields, and is_collision is sampled in CHECK.
- One sub-module is natural: `pair_iter`, holding the i/j counters and the advance/last-pair logic.

Test Plan:
- Shared setup for the first four tests: width=height=10, u=(16'h4000,0), v=(0,16'h4000), obj0 pos=(14,14) Q8.24 (32'h0E00_0000).
  - n=2, obj1 pos=(40,14) -> no hit_valid, hit_count=0, done exactly 6 cycles after start.
  - n=2, obj1 pos=(20,14), hit_ready tied 1 -> one hit (a=0,b=1), hit_count=1, done at cycle 7.
- n=3, obj1=(20,14), obj2=(-20,14), hit_ready held 0 for 5 cycles -> single hit (0,1). hit_a/hit_b stable during the stall, transfer on ready. Total 20 cycles; (0,2) and (1,2) give no hit.
- num_active=1 and num_active=0 -> done pulse 1 cycle after start, obj_rd_en never asserted, hit_count=0.
- Overlapping scan: n=8, all objects at the same position -> 28 hits in lexicographic order, hit_count=28. A start pulse mid-scan is ignored (no restart).
- Reset_n pulsed low during EMIT -> outputs return to reset values immediately, no done pulse. A new start afterwards performs a clean full scan.
